mc_control_unit: RTL and testbench

- Parametrised multicycle RV32I control FSM; next generation of the core's control unit.
- Decodes opcode/funct3/funct7 and drives every datapath select and write enable per state.
- Covers loads, stores, R/I ALU, all six branches, JAL, JALR, LUI, AUIPC.
- Adds an optional memory wait-state handshake and a sticky illegal-instruction trap.

---
 rtl/mc_control_unit.sv | 195 +++++++++++++++++++
 tb/tb_mc_control_unit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multicycle RV32I control FSM: decodes the instruction register and sequences
// datapath selects/enables, with optional memory wait states and a sticky trap.
module mc_control_unit #(
  parameter int MEM_WAIT_EN = 1,
  parameter int ALU_OP_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                pc_we,
  output logic                mem_addr_src,
  output logic                mem_we,
  output logic                mem_re,
  output logic                instr_we,
  output logic [1:0]          result_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          alu_a_src,
  output logic [1:0]          alu_b_src,
  output logic                rf_we,
  output logic                illegal,
  output logic [3:0]          state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,  S_DECODE    = 4'd1,  S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,  S_MEM_WB    = 4'd4,  S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,  S_ALU_WB    = 4'd7,  S_EXEC_I    = 4'd8,
    S_JAL       = 4'd9,  S_BRANCH    = 4'd10, S_JALR_LINK = 4'd11,
    S_JALR_JUMP = 4'd12, S_LUI       = 4'd13, S_TRAP      = 4'd14
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR   = 4'd3,
    ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA  = 4'd7,
    ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_PASS_B = 4'd10
  } alu_op_e;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10, RES_PC = 2'b11;
  localparam logic [1:0] A_PC = 2'b00, A_OLDPC = 2'b01, A_REG = 2'b10;
  localparam logic [1:0] B_REG = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;

  state_e  state_q;
  logic    illegal_q;
  logic    rdy;
  logic    br_legal, br_taken;
  alu_op_e br_op, alu_sel;
  logic    pc_we_m, instr_we_m, mem_we_m, mem_re_m, rf_we_m;
  logic    unused_funct7;

  assign rdy           = mem_ready | (MEM_WAIT_EN == 0);
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  function automatic state_e decode_next(input logic [6:0] opc);
    state_e nxt;
    case (opc)
      OPC_LOAD, OPC_STORE: nxt = S_MEM_ADDR;
      OPC_R:               nxt = S_EXEC_R;
      OPC_I:               nxt = S_EXEC_I;
      OPC_JAL:             nxt = S_JAL;
      OPC_JALR:            nxt = S_JALR_LINK;
      OPC_BR:              nxt = S_BRANCH;
      OPC_LUI:             nxt = S_LUI;
      OPC_AUIPC:           nxt = S_ALU_WB;
      default:             nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

  // funct7[5] selects SUB only for register-register ops; shifts honour it in both.
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt, input logic is_r);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    br_legal = 1'b1;
    br_taken = 1'b0;
    br_op    = ALU_ADD;
    case (funct3)
      3'b000:  begin br_op = ALU_SUB;  br_taken = alu_zero;  end
      3'b001:  begin br_op = ALU_SUB;  br_taken = !alu_zero; end
      3'b100:  begin br_op = ALU_SLT;  br_taken = !alu_zero; end
      3'b101:  begin br_op = ALU_SLT;  br_taken = alu_zero;  end
      3'b110:  begin br_op = ALU_SLTU; br_taken = !alu_zero; end
      3'b111:  begin br_op = ALU_SLTU; br_taken = alu_zero;  end
      default: br_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (state_q == S_TRAP) illegal_q <= 1'b1;
      case (state_q)
        S_FETCH:     if (rdy) state_q <= S_DECODE;
        S_DECODE:    state_q <= decode_next(opcode);
        S_MEM_ADDR:  state_q <= (opcode == OPC_LOAD) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (rdy) state_q <= S_MEM_WB;
        S_MEM_WRITE: if (rdy) state_q <= S_FETCH;
        S_EXEC_R, S_EXEC_I, S_JAL, S_LUI: state_q <= S_ALU_WB;
        S_JALR_LINK: state_q <= S_JALR_JUMP;
        S_BRANCH:    state_q <= br_legal ? S_FETCH : S_TRAP;
        S_TRAP:      state_q <= S_TRAP;
        default:     state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_we_m      = 1'b0;
    instr_we_m   = 1'b0;
    mem_we_m     = 1'b0;
    mem_re_m     = 1'b0;
    rf_we_m      = 1'b0;
    mem_addr_src = 1'b0;
    result_src   = RES_ALUOUT;
    alu_sel      = ALU_ADD;
    alu_a_src    = A_PC;
    alu_b_src    = B_REG;
    case (state_q)
      S_FETCH: begin
        mem_re_m   = 1'b1;
        alu_b_src  = B_FOUR;
        result_src = RES_ALU;
        instr_we_m = rdy;
        pc_we_m    = rdy;
      end
      S_DECODE:    begin alu_a_src = A_OLDPC; alu_b_src = B_IMM; end
      S_MEM_ADDR:  begin alu_a_src = A_REG;   alu_b_src = B_IMM; end
      S_MEM_READ:  begin mem_addr_src = 1'b1; mem_re_m = 1'b1; end
      S_MEM_WB:    begin result_src = RES_MEM; rf_we_m = 1'b1; end
      S_MEM_WRITE: begin mem_addr_src = 1'b1; mem_we_m = 1'b1; end
      S_EXEC_R: begin
        alu_a_src = A_REG;
        alu_sel   = arith_op(funct3, funct7[5], 1'b1);
      end
      S_EXEC_I: begin
        alu_a_src = A_REG;
        alu_b_src = B_IMM;
        alu_sel   = arith_op(funct3, funct7[5], 1'b0);
      end
      S_ALU_WB:    rf_we_m = 1'b1;
      S_JAL:       begin alu_a_src = A_OLDPC; alu_b_src = B_FOUR; pc_we_m = 1'b1; end
      S_BRANCH:    begin alu_a_src = A_REG; alu_sel = br_op; pc_we_m = br_taken; end
      S_JALR_LINK: begin result_src = RES_PC; rf_we_m = 1'b1; end
      S_JALR_JUMP: begin
        alu_a_src  = A_REG;
        alu_b_src  = B_IMM;
        result_src = RES_ALU;
        pc_we_m    = 1'b1;
      end
      S_LUI:       begin alu_b_src = B_IMM; alu_sel = ALU_PASS_B; end
      default: ;
    endcase
  end

  // Reset is asynchronous, so the enables are masked directly to block any write in that cycle.
  assign pc_we     = pc_we_m    & ~rst;
  assign instr_we  = instr_we_m & ~rst;
  assign mem_we    = mem_we_m   & ~rst;
  assign mem_re    = mem_re_m   & ~rst;
  assign rf_we     = rf_we_m    & ~rst;
  assign alu_op    = ALU_OP_W'(alu_sel);
  assign illegal   = illegal_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: two instances (wait states off/on) driven by
// random instruction streams; expected per-cycle outputs come from an instruction-level model.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       alu_zero, mem_ready;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_we;
    logic       addr_src;
    logic       mem_we;
    logic       mem_re;
    logic       instr_we;
    logic [1:0] res;
    logic [3:0] alu;
    logic [1:0] a;
    logic [1:0] b;
    logic       rf_we;
    logic       ill;
  } vec_t;

  typedef struct {
    vec_t v;
    logic which;
    logic ill_dc;
    int   cyc;
  } sb_t;

  typedef enum int {K_LOAD, K_STORE, K_R, K_I, K_JAL, K_JALR, K_BR, K_LUI,
                    K_AUIPC, K_BAD_OP, K_BAD_BR} kind_e;

  sb_t   sb[$];
  int    total = 0;
  int    bad = 0;
  int    mode = 0;
  int    cyc_cnt = 0;
  kind_e kind;
  int    abort_at;

  // Instance 0: wait states disabled. Instance 1: wait states enabled.
  logic       pc_we0, addr0, mem_we0, mem_re0, iwe0, rfwe0, ill0;
  logic [1:0] res0, a0, b0;
  logic [3:0] alu0, st0;
  logic       pc_we1, addr1, mem_we1, mem_re1, iwe1, rfwe1, ill1;
  logic [1:0] res1, a1, b1;
  logic [3:0] alu1, st1;
  vec_t       act0, act1;

  mc_control_unit #(.MEM_WAIT_EN(0), .ALU_OP_W(4)) dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_we(pc_we0), .mem_addr_src(addr0),
    .mem_we(mem_we0), .mem_re(mem_re0), .instr_we(iwe0), .result_src(res0), .alu_op(alu0),
    .alu_a_src(a0), .alu_b_src(b0), .rf_we(rfwe0), .illegal(ill0), .state_dbg(st0)
  );

  mc_control_unit #(.MEM_WAIT_EN(1), .ALU_OP_W(4)) dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_we(pc_we1), .mem_addr_src(addr1),
    .mem_we(mem_we1), .mem_re(mem_re1), .instr_we(iwe1), .result_src(res1), .alu_op(alu1),
    .alu_a_src(a1), .alu_b_src(b1), .rf_we(rfwe1), .illegal(ill1), .state_dbg(st1)
  );

  assign act0 = {st0, pc_we0, addr0, mem_we0, mem_re0, iwe0, res0, alu0, a0, b0, rfwe0, ill0};
  assign act1 = {st1, pc_we1, addr1, mem_we1, mem_re1, iwe1, res1, alu1, a1, b1, rfwe1, ill1};

  // Expected outputs for one cycle spent in state s of the instruction's walk.
  function automatic vec_t model_out(input logic [3:0] s, input logic rdy, input logic [3:0] op,
                                     input logic taken, input logic ill);
    vec_t v;
    v     = '0;
    v.st  = s;
    v.ill = ill;
    case (s)
      4'd0:  begin v.mem_re = 1'b1; v.b = 2'b10; v.res = 2'b10; v.instr_we = rdy; v.pc_we = rdy; end
      4'd1:  begin v.a = 2'b01; v.b = 2'b01; end
      4'd2:  begin v.a = 2'b10; v.b = 2'b01; end
      4'd3:  begin v.addr_src = 1'b1; v.mem_re = 1'b1; end
      4'd4:  begin v.res = 2'b01; v.rf_we = 1'b1; end
      4'd5:  begin v.addr_src = 1'b1; v.mem_we = 1'b1; end
      4'd6:  begin v.a = 2'b10; v.alu = op; end
      4'd7:  v.rf_we = 1'b1;
      4'd8:  begin v.a = 2'b10; v.b = 2'b01; v.alu = op; end
      4'd9:  begin v.a = 2'b01; v.b = 2'b10; v.pc_we = 1'b1; end
      4'd10: begin v.a = 2'b10; v.alu = op; v.pc_we = taken; end
      4'd11: begin v.res = 2'b11; v.rf_we = 1'b1; end
      4'd12: begin v.a = 2'b10; v.b = 2'b01; v.res = 2'b10; v.pc_we = 1'b1; end
      4'd13: begin v.b = 2'b01; v.alu = 4'd10; end
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] imm_op(input logic [2:0] f3, input logic b5);
    case (f3)
      3'd0: return 4'd0;
      3'd1: return 4'd5;
      3'd2: return 4'd8;
      3'd3: return 4'd9;
      3'd4: return 4'd4;
      3'd5: return b5 ? 4'd7 : 4'd6;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] opc);
    return opc inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                       7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111};
  endfunction

  task automatic push(input vec_t v, input logic dc);
    sb_t e;
    e.v      = v;
    e.which  = (mode != 0);
    e.ill_dc = dc;
    e.cyc    = cyc_cnt;
    sb.push_back(e);
  endtask

  // Called at posedge+1: one cycle held in reset, released after the next edge.
  task automatic do_reset();
    vec_t v;
    rst       = 1'b1;
    mem_ready = 1'($urandom);
    alu_zero  = 1'($urandom);
    v         = model_out(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    v.mem_re  = 1'b0;
    push(v, 1'b0);
    @(posedge clk); #1;
    cyc_cnt++;
    rst = 1'b0;
  endtask

  task automatic run_instr(input kind_e k, input int sel, input int abort, input int fetch_wait,
                           input logic use_ops, input logic [31:0] ra_in, input logic [31:0] rb_in);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [3:0]  op, s;
    logic [31:0] ra, rb, diff;
    logic        taken, zero_br, lt_s, lt_u, b5, waitable, rdy, first_trap, dc;
    logic [3:0]  seq[$];
    int          idx, waits, fw, cyc, r;
    opc     = 7'b0;
    f3      = 3'($urandom);
    f7      = 7'($urandom);
    op      = 4'd0;
    taken   = 1'b0;
    zero_br = 1'($urandom);
    ra      = use_ops ? ra_in : $urandom;
    rb      = use_ops ? rb_in : (($urandom_range(0, 3) == 0) ? ra : $urandom);
    diff    = ra - rb;
    lt_s    = $signed(ra) < $signed(rb);
    lt_u    = ra < rb;
    seq     = {4'd0, 4'd1};
    case (k)
      K_LOAD:  begin opc = 7'b0000011; seq.push_back(4'd2); seq.push_back(4'd3); seq.push_back(4'd4); end
      K_STORE: begin opc = 7'b0100011; seq.push_back(4'd2); seq.push_back(4'd5); end
      K_R: begin
        opc = 7'b0110011;
        r   = (sel >= 0) ? sel : int'($urandom_range(0, 9));
        case (r)
          0: {f3, b5, op} = {3'd0, 1'b0, 4'd0};   // ADD
          1: {f3, b5, op} = {3'd0, 1'b1, 4'd1};   // SUB
          2: {f3, b5, op} = {3'd1, 1'b0, 4'd5};   // SLL
          3: {f3, b5, op} = {3'd2, 1'b0, 4'd8};   // SLT
          4: {f3, b5, op} = {3'd3, 1'b0, 4'd9};   // SLTU
          5: {f3, b5, op} = {3'd4, 1'b0, 4'd4};   // XOR
          6: {f3, b5, op} = {3'd5, 1'b0, 4'd6};   // SRL
          7: {f3, b5, op} = {3'd5, 1'b1, 4'd7};   // SRA
          8: {f3, b5, op} = {3'd6, 1'b0, 4'd3};   // OR
          default: {f3, b5, op} = {3'd7, 1'b0, 4'd2};  // AND
        endcase
        f7 = {1'b0, b5, 5'b0};
        seq.push_back(4'd6); seq.push_back(4'd7);
      end
      K_I: begin
        opc = 7'b0010011;
        if (sel >= 0) f3 = 3'(sel);
        op = imm_op(f3, f7[5]);
        seq.push_back(4'd8); seq.push_back(4'd7);
      end
      K_JAL:   begin opc = 7'b1101111; seq.push_back(4'd9); seq.push_back(4'd7); end
      K_JALR:  begin opc = 7'b1100111; seq.push_back(4'd11); seq.push_back(4'd12); end
      K_BR: begin
        opc = 7'b1100011;
        if (sel >= 0) f3 = 3'(sel);
        else begin
          r  = int'($urandom_range(0, 5));
          f3 = (r < 2) ? 3'(r) : 3'(r + 2);
        end
        // Branch decision from RISC-V semantics; alu_zero is what the ALU op would produce.
        case (f3)
          3'd0:    begin op = 4'd1; taken = (ra == rb); zero_br = (diff == 32'd0); end
          3'd1:    begin op = 4'd1; taken = (ra != rb); zero_br = (diff == 32'd0); end
          3'd4:    begin op = 4'd8; taken = lt_s;  zero_br = !lt_s; end
          3'd5:    begin op = 4'd8; taken = !lt_s; zero_br = !lt_s; end
          3'd6:    begin op = 4'd9; taken = lt_u;  zero_br = !lt_u; end
          default: begin op = 4'd9; taken = !lt_u; zero_br = !lt_u; end
        endcase
        seq.push_back(4'd10);
      end
      K_LUI:   begin opc = 7'b0110111; seq.push_back(4'd13); seq.push_back(4'd7); end
      K_AUIPC: begin opc = 7'b0010111; seq.push_back(4'd7); end
      K_BAD_OP: begin
        opc = (sel >= 0) ? 7'(sel) : 7'($urandom);
        if (is_legal(opc)) opc = 7'h7F;
        repeat (10) seq.push_back(4'd14);
      end
      default: begin
        opc = 7'b1100011;
        f3  = {2'b01, 1'($urandom)};
        seq.push_back(4'd10);
        repeat (10) seq.push_back(4'd14);
      end
    endcase

    opcode     = opc;
    funct3     = f3;
    funct7     = f7;
    idx        = 0;
    waits      = 0;
    fw         = fetch_wait;
    cyc        = 0;
    first_trap = 1'b1;
    while (idx < seq.size()) begin
      if (cyc == abort) begin
        do_reset();
        return;
      end
      s        = seq[idx];
      waitable = (s == 4'd0) || (s == 4'd3) || (s == 4'd5);
      if (s == 4'd0 && fw > 0) begin
        mem_ready = 1'b0;
        fw--;
      end else if (mode != 0 && waitable)
        mem_ready = (waits < 3 && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      else
        mem_ready = 1'($urandom);
      rdy      = (mode == 0) ? 1'b1 : mem_ready;
      alu_zero = (s == 4'd10) ? zero_br : 1'($urandom);
      dc       = (s == 4'd14) && first_trap;
      push(model_out(s, rdy, op, taken, (s == 4'd14) && !first_trap), dc);
      if (s == 4'd14) first_trap = 1'b0;
      @(posedge clk); #1;
      cyc++;
      cyc_cnt++;
      if (waitable && !rdy) waits++;
      else begin
        idx++;
        waits = 0;
      end
    end
    if (k == K_BAD_OP || k == K_BAD_BR) do_reset();
  endtask

  // Monitor: every mid-cycle sample pops one expectation and compares the selected instance.
  always @(negedge clk) begin
    sb_t  e;
    vec_t act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = e.which ? act1 : act0;
      if (e.ill_dc) act.ill = e.v.ill;
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL outputs cyc=%0d dut%0d state=%0d: got %h (st=%0d alu=%0d) want %h (st=%0d alu=%0d)",
                 e.cyc, e.which, e.v.st, act, act.st, act.alu, e.v, e.v.st, e.v.alu);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    opcode    = 7'd0;
    funct3    = 3'd0;
    funct7    = 7'd0;
    alu_zero  = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;

    mode = 0;
    do_reset();
    run_instr(K_LOAD, -1, -1, 0, 1'b0, 32'd0, 32'd0);
    run_instr(K_LOAD, -1, -1, 2, 1'b0, 32'd0, 32'd0);
    repeat (60) begin
      kind     = kind_e'($urandom_range(0, 10));
      abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : -1;
      run_instr(kind, -1, abort_at, 0, 1'b0, 32'd0, 32'd0);
    end

    mode = 1;
    do_reset();
    run_instr(K_LOAD, -1, -1, 3, 1'b0, 32'd0, 32'd0);
    run_instr(K_BR, 5, -1, 0, 1'b1, 32'd5, 32'hFFFF_FFFD);
    run_instr(K_BR, 5, -1, 0, 1'b1, 32'hFFFF_FFFD, 32'd5);
    run_instr(K_R, 7, -1, 0, 1'b0, 32'd0, 32'd0);
    run_instr(K_JALR, -1, -1, 0, 1'b0, 32'd0, 32'd0);
    run_instr(K_STORE, -1, -1, 0, 1'b0, 32'd0, 32'd0);
    run_instr(K_LOAD, -1, 4, 0, 1'b0, 32'd0, 32'd0);
    run_instr(K_BAD_OP, 7'h7F, -1, 0, 1'b0, 32'd0, 32'd0);
    repeat (150) begin
      kind     = kind_e'($urandom_range(0, 10));
      abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : -1;
      run_instr(kind, -1, abort_at, 0, 1'b0, 32'd0, 32'd0);
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard drain: %0d expectations left, required 0", sb.size());
      bad++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
